axi4_stream_pkt_limiter: RTL and testbench

Packet-length guard placed directly upstream of the single-clock AXI4-Stream FIFO. It forwards packets unchanged while they stay within `MAX_PKT_WORDS` beats. Longer packets are truncated: the last allowed beat is forwarded with `tlast` forced high, and the remainder of the packet is silently discarded. This keeps downstream buffers from receiving unbounded packets. Output is registered with one beat of latency and supports full throughput.

---
 rtl/axi4_stream_pkg.sv | 33 +++
 rtl/axi4_stream_if.sv | 33 +++
 rtl/axi4_stream_pkt_limiter.sv | 149 ++++++++++++++
 tb/tb_axi4_stream_pkt_limiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_stream_pkg.sv
// rtl/axi4_stream_pkg.sv - shared AXI4-Stream types for the packet limiter and downstream FIFO
package axi4_stream_pkg;

  // Default stream widths used by the shared beat struct.
  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;
  localparam int AXIS_USER_WIDTH = 1;
  localparam int AXIS_DEST_WIDTH = 1;
  localparam int AXIS_ID_WIDTH   = 1;

  // Limiter FSM: PASS forwards beats, DROP discards the tail of an over-long packet.
  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } state_t;

  // One stream beat with all sidebands, at the default widths.
  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic [AXIS_KEEP_WIDTH-1:0] tstrb;
    logic [AXIS_KEEP_WIDTH-1:0] tkeep;
    logic                       tlast;
    logic [AXIS_USER_WIDTH-1:0] tuser;
    logic [AXIS_DEST_WIDTH-1:0] tdest;
    logic [AXIS_ID_WIDTH-1:0]   tid;
  } axis_beat_t;

  // Saturating 16-bit increment for event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream bundle with master/slave views
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic [DEST_WIDTH-1:0] tdest;
  logic [ID_WIDTH-1:0]   tid;
  logic                  tvalid;
  logic                  tready;

  // Source side: drives payload and tvalid, observes tready.
  modport master (
    output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
    input  tready
  );

  // Sink side: observes payload and tvalid, drives tready.
  modport slave (
    input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
    output tready
  );

endinterface

// File: rtl/axi4_stream_pkt_limiter.sv
// rtl/axi4_stream_pkt_limiter.sv - truncates AXI4-Stream packets longer than MAX_PKT_WORDS beats
module axi4_stream_pkt_limiter
  import axi4_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int USER_WIDTH    = 1,
  parameter int DEST_WIDTH    = 1,
  parameter int ID_WIDTH      = 1,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  axi4_stream_if.slave         pkt_i,
  axi4_stream_if.master        pkt_o,
  output logic                 trunc_o,
  output logic [15:0]          trunc_cnt_o
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = $clog2(MAX_PKT_WORDS + 1);
  // Index of the last beat a packet may carry before it is cut.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_WORDS - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic [DEST_WIDTH-1:0] tdest;
    logic [ID_WIDTH-1:0]   tid;
  } beat_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [CNT_W-1:0]   w_word_cnt_nxt;
  beat_t              r_beat;
  beat_t              w_in_beat;
  beat_t              w_load_beat;
  logic               r_out_valid;
  logic               w_in_ready;
  logic               w_load;
  logic               w_force_last;
  logic               r_trunc;
  logic [15:0]        r_trunc_cnt;

  assign w_in_beat = '{
    tdata: pkt_i.tdata,
    tstrb: pkt_i.tstrb,
    tkeep: pkt_i.tkeep,
    tlast: pkt_i.tlast,
    tuser: pkt_i.tuser,
    tdest: pkt_i.tdest,
    tid:   pkt_i.tid
  };

  // The forced-tlast beat is the incoming beat with only tlast overridden.
  always_comb begin
    w_load_beat       = w_in_beat;
    w_load_beat.tlast = w_in_beat.tlast | w_force_last;
  end

  // Next state, beat count and input ready; ready never looks at tvalid.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_in_ready     = 1'b1;
    w_load         = 1'b0;
    w_force_last   = 1'b0;
    unique case (r_state)
      PASS: begin
        w_in_ready = !r_out_valid || pkt_o.tready;
        if (pkt_i.tvalid && w_in_ready) begin
          w_load = 1'b1;
          if (pkt_i.tlast) begin
            w_word_cnt_nxt = '0;
          end else if (r_word_cnt == LAST_IDX) begin
            w_force_last   = 1'b1;
            w_word_cnt_nxt = '0;
            w_state_nxt    = DROP;
          end else begin
            w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
          end
        end
      end
      DROP: begin
        if (pkt_i.tvalid && pkt_i.tlast) begin
          w_state_nxt = PASS;
        end
      end
      default: begin
        w_state_nxt = PASS;
      end
    endcase
  end

  // FSM state and per-packet beat counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= PASS;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  // Output skid register: load replaces contents, drain without load empties it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_beat      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_beat      <= w_load_beat;
      r_out_valid <= 1'b1;
    end else if (pkt_o.tready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Truncation pulse lines up with the forced-tlast beat; counter saturates.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_trunc     <= 1'b0;
      r_trunc_cnt <= 16'd0;
    end else begin
      r_trunc <= w_load && w_force_last;
      if (w_load && w_force_last) begin
        r_trunc_cnt <= sat_inc16(r_trunc_cnt);
      end
    end
  end

  assign pkt_i.tready = w_in_ready;

  assign pkt_o.tvalid = r_out_valid;
  assign pkt_o.tdata  = r_beat.tdata;
  assign pkt_o.tstrb  = r_beat.tstrb;
  assign pkt_o.tkeep  = r_beat.tkeep;
  assign pkt_o.tlast  = r_beat.tlast;
  assign pkt_o.tuser  = r_beat.tuser;
  assign pkt_o.tdest  = r_beat.tdest;
  assign pkt_o.tid    = r_beat.tid;

  assign trunc_o     = r_trunc;
  assign trunc_cnt_o = r_trunc_cnt;

endmodule

// File: tb/tb_axi4_stream_pkt_limiter.sv
// tb/tb_axi4_stream_pkt_limiter.sv - randomized scoreboard bench for the packet limiter
`timescale 1ns/1ps
module tb_axi4_stream_pkt_limiter;
  import axi4_stream_pkg::*;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trunc;
  logic [15:0] trunc_cnt;

  int checks = 0;
  int failures = 0;

  axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) in_if ();
  axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) out_if ();

  axi4_stream_pkt_limiter #(
    .DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1), .MAX_PKT_WORDS(MAX)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pkt_i(in_if), .pkt_o(out_if),
    .trunc_o(trunc), .trunc_cnt_o(trunc_cnt)
  );

  always #5 clk = ~clk;

  axis_beat_t exp_q[$];
  axis_beat_t got_q[$];
  int         got_rd = 0;
  int         exp_trunc = 0;
  bit         bp_en = 1'b0;
  int         trunc_hi = 0;
  int         trunc_bad = 0;
  int         stall_bad = 0;
  bit         mon_stall = 1'b0;
  axis_beat_t mon_prev;

  function automatic axis_beat_t out_beat();
    axis_beat_t b;
    b.tdata = out_if.tdata; b.tstrb = out_if.tstrb; b.tkeep = out_if.tkeep;
    b.tlast = out_if.tlast; b.tuser = out_if.tuser; b.tdest = out_if.tdest; b.tid = out_if.tid;
    return b;
  endfunction

  // Reference: beat idx of a len-beat packet survives iff idx < MAX; the last survivor ends the packet.
  function automatic bit model_keeps(input int idx);
    return idx < MAX;
  endfunction

  function automatic axis_beat_t model_out(input axis_beat_t b, input int idx, input int len);
    axis_beat_t r;
    r = b;
    r.tlast = (idx == len - 1) || (idx == MAX - 1);
    return r;
  endfunction

  function automatic axis_beat_t rand_beat(input logic [31:0] d, input bit last);
    axis_beat_t b;
    b.tdata = d;
    b.tstrb = 4'($urandom_range(0, 15));
    b.tkeep = 4'($urandom_range(0, 15));
    b.tlast = last;
    b.tuser = 1'($urandom_range(0, 1));
    b.tdest = 1'($urandom_range(0, 1));
    b.tid   = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // Sink ready: always high, or random when backpressure is enabled.
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor: collects accepted beats, stall stability and trunc_o alignment.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_stall = 1'b0;
      end else begin
        if (mon_stall && (out_if.tvalid !== 1'b1 || out_beat() !== mon_prev)) stall_bad++;
        if (trunc === 1'b1) begin
          trunc_hi++;
          if (!(out_if.tvalid === 1'b1 && out_if.tlast === 1'b1)) trunc_bad++;
        end
        if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) got_q.push_back(out_beat());
        mon_stall = (out_if.tvalid === 1'b1) && (out_if.tready !== 1'b1);
        mon_prev = out_beat();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic drive_beat(input axis_beat_t b, output int waits, output bit ok);
    in_if.tdata = b.tdata; in_if.tstrb = b.tstrb; in_if.tkeep = b.tkeep; in_if.tlast = b.tlast;
    in_if.tuser = b.tuser; in_if.tdest = b.tdest; in_if.tid = b.tid; in_if.tvalid = 1'b1;
    waits = 0;
    ok = 1'b0;
    while (!ok && waits < 100) begin
      @(negedge clk);
      ok = (in_if.tready === 1'b1);
      @(posedge clk);
      #1;
      waits++;
    end
  endtask

  task automatic send_pkt(input int len, input logic [31:0] base, input bit seq, input int gap_max,
                          output int drop_wait_max, output bit ok);
    axis_beat_t b;
    int w;
    bit bok;
    ok = 1'b1;
    drop_wait_max = 0;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(seq ? base + 32'(i) : $urandom, i == len - 1);
      drive_beat(b, w, bok);
      if (!bok) ok = 1'b0;
      if (model_keeps(i)) exp_q.push_back(model_out(b, i, len));
      else if (w > drop_wait_max) drop_wait_max = w;
      if (gap_max > 0) begin
        int n;
        n = $urandom_range(0, gap_max);
        if (n > 0) begin
          in_if.tvalid = 1'b0;
          repeat (n) begin @(posedge clk); #1; end
        end
      end
    end
    in_if.tvalid = 1'b0;
    if (len > MAX) exp_trunc++;
  endtask

  task automatic wait_drain(output bit ok);
    int n;
    n = 0;
    while (got_q.size() < got_rd + exp_q.size() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    ok = (got_q.size() == got_rd + exp_q.size());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_if.tvalid = 1'b0; in_if.tlast = 1'b0; in_if.tdata = '0; in_if.tstrb = '0;
    in_if.tkeep = '0; in_if.tuser = '0; in_if.tdest = '0; in_if.tid = '0;
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (out_if.tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", out_if.tvalid); end
    checks++;
    if (out_beat() !== '0) begin failures++; $display("FAIL reset_fields got=%h exp=0", out_beat()); end
    checks++;
    if (trunc !== 1'b0 || trunc_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_trunc got=%b/%0d exp=0/0", trunc, trunc_cnt);
    end
    checks++;
    if (in_if.tready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_if.tready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_short();
    axis_beat_t b;
    int w;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      b = rand_beat(32'hA000 + 32'(i), i == 2);
      drive_beat(b, w, ok);
      exp_q.push_back(model_out(b, i, 3));
      if (i == 0) begin
        checks++;
        if (out_if.tvalid !== 1'b1 || out_if.tdata !== 32'hA000) begin
          failures++; $display("FAIL short_latency got=%b/%h exp=1/0000a000", out_if.tvalid, out_if.tdata);
        end
      end
    end
    in_if.tvalid = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL short_count got=%0d exp=%0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin
        failures++; $display("FAIL short_beat%0d got=%h exp=%h", i, got_q[got_rd + i], exp_q[i]);
      end
    end
    got_rd += exp_q.size();
    exp_q.delete();
    checks++;
    if (trunc_cnt !== 16'd0) begin failures++; $display("FAIL short_trunc_cnt got=%0d exp=0", trunc_cnt); end
  endtask

  task automatic test_exact();
    int dw;
    int hi0;
    bit ok;
    hi0 = trunc_hi;
    send_pkt(MAX, 32'hB000, 1'b1, 0, dw, ok);
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL exact_count got=%0d exp=%0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin
        failures++; $display("FAIL exact_beat%0d got=%h exp=%h", i, got_q[got_rd + i], exp_q[i]);
      end
    end
    got_rd += exp_q.size();
    exp_q.delete();
    checks++;
    if (trunc_hi != hi0 || trunc_cnt !== 16'd0) begin
      failures++; $display("FAIL exact_no_trunc got=%0d/%0d exp=0/0", trunc_hi - hi0, trunc_cnt);
    end
  endtask

  task automatic test_trunc();
    int dw;
    int hi0;
    bit ok;
    hi0 = trunc_hi;
    send_pkt(7, 32'd0, 1'b1, 0, dw, ok);
    checks++;
    if (dw != 1) begin failures++; $display("FAIL trunc_drop_ready got=%0d exp=1 cycles", dw); end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL trunc_count got=%0d exp=%0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin
        failures++; $display("FAIL trunc_beat%0d got=%h exp=%h", i, got_q[got_rd + i], exp_q[i]);
      end
    end
    got_rd += exp_q.size();
    exp_q.delete();
    checks++;
    if (trunc_hi - hi0 != 1 || trunc_bad != 0) begin
      failures++; $display("FAIL trunc_pulse got=%0d/%0d exp=1/0", trunc_hi - hi0, trunc_bad);
    end
    checks++;
    if (trunc_cnt !== 16'(exp_trunc)) begin failures++; $display("FAIL trunc_cnt got=%0d exp=%0d", trunc_cnt, exp_trunc); end
  endtask

  task automatic test_back_to_back();
    int dw;
    bit ok1;
    bit ok2;
    bit ok;
    send_pkt(6, 32'hC000, 1'b1, 0, dw, ok1);
    send_pkt(2, 32'h0000000A, 1'b1, 0, dw, ok2);
    wait_drain(ok);
    checks++;
    if (!(ok && ok1 && ok2)) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size() - got_rd, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin
        failures++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, got_q[got_rd + i], exp_q[i]);
      end
    end
    got_rd += exp_q.size();
    exp_q.delete();
    checks++;
    if (trunc_cnt !== 16'(exp_trunc)) begin failures++; $display("FAIL b2b_trunc_cnt got=%0d exp=%0d", trunc_cnt, exp_trunc); end
  endtask

  task automatic test_random_backpressure();
    int dw;
    int hi0;
    int t0;
    bit ok;
    bit all_ok;
    hi0 = trunc_hi;
    t0 = exp_trunc;
    all_ok = 1'b1;
    bp_en = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      send_pkt($urandom_range(1, 10), 32'd0, 1'b0, 2, dw, ok);
      if (!ok) all_ok = 1'b0;
    end
    wait_drain(ok);
    bp_en = 1'b0;
    checks++;
    if (!(ok && all_ok)) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - got_rd, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin
        failures++; $display("FAIL rand_beat%0d got=%h exp=%h", i, got_q[got_rd + i], exp_q[i]);
      end
    end
    got_rd += exp_q.size();
    exp_q.delete();
    checks++;
    if (stall_bad != 0) begin failures++; $display("FAIL rand_stall_stable got=%0d exp=0 violations", stall_bad); end
    checks++;
    if (trunc_hi - hi0 != exp_trunc - t0 || trunc_bad != 0) begin
      failures++; $display("FAIL rand_trunc_pulses got=%0d/%0d exp=%0d/0", trunc_hi - hi0, trunc_bad, exp_trunc - t0);
    end
    checks++;
    if (trunc_cnt !== 16'(exp_trunc)) begin failures++; $display("FAIL rand_trunc_cnt got=%0d exp=%0d", trunc_cnt, exp_trunc); end
  endtask

  task automatic test_reset_mid_drop();
    axis_beat_t b;
    int w;
    int dw;
    bit ok;
    bit bok;
    bok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = rand_beat(32'hD000 + 32'(i), i == 5);
      drive_beat(b, w, ok);
      if (!ok) bok = 1'b0;
      if (model_keeps(i)) exp_q.push_back(model_out(b, i, 6));
    end
    checks++;
    if (!bok || got_q.size() != got_rd + exp_q.size()) begin
      failures++; $display("FAIL rstdrop_pre_count got=%0d exp=%0d", got_q.size() - got_rd, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin
        failures++; $display("FAIL rstdrop_pre_beat%0d got=%h exp=%h", i, got_q[got_rd + i], exp_q[i]);
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
    rst_n = 1'b0;
    in_if.tvalid = 1'b0;
    #1;
    checks++;
    if (out_if.tvalid !== 1'b0 || trunc_cnt !== 16'd0 || trunc !== 1'b0) begin
      failures++; $display("FAIL rstdrop_async got=%b/%0d/%b exp=0/0/0", out_if.tvalid, trunc_cnt, trunc);
    end
    exp_trunc = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(2, 32'hE000, 1'b1, 0, dw, ok);
    send_pkt(MAX, 32'hF000, 1'b1, 0, dw, bok);
    wait_drain(ok);
    checks++;
    if (!(ok && bok)) begin failures++; $display("FAIL rstdrop_post_count got=%0d exp=%0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[got_rd + i] !== exp_q[i]) begin
        failures++; $display("FAIL rstdrop_post_beat%0d got=%h exp=%h", i, got_q[got_rd + i], exp_q[i]);
      end
    end
    got_rd += exp_q.size();
    exp_q.delete();
    checks++;
    if (trunc_cnt !== 16'd0) begin failures++; $display("FAIL rstdrop_post_trunc_cnt got=%0d exp=0", trunc_cnt); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_exact();
    test_trunc();
    test_back_to_back();
    test_random_backpressure();
    test_reset_mid_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
